// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch PC register, next-PC selection and misprediction recovery.
//    clk, reset (sync, active-low)
//    stall, imem_ready, imem_rdata           : hazard hold and instruction memory response
//    predict_taken, btb_hit, predict_target  : prediction for the current pc_out
//    ex_mem_*, bpu_correct, actual_taken     : branch resolution from EX/MEM
//    pc_out, flush                           : fetch address and combinational redirect
//    if_id_*                                 : IF/ID pipeline register
//    FETCH_PERF_CNT_EN adds perf_redirects / perf_fetches (saturating 16-bit)
module fetch_pc_unit #(
   parameter int              PC_W     = 12,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   input  logic            predict_taken,
   input  logic            btb_hit,
   input  logic [PC_W-1:0] predict_target,
   input  logic            ex_mem_valid,
   input  logic [PC_W-1:0] ex_mem_pc_in,
   input  logic            ex_mem_predict_taken,
   input  logic [PC_W-1:0] ex_mem_predict_target,
   input  logic [PC_W-1:0] ex_mem_branch_target,
   input  logic            bpu_correct,
   input  logic            actual_taken,
   output logic [PC_W-1:0] pc_out,
   output logic            flush,
   output logic            if_id_valid,
   output logic [31:0]     if_id_instr,
   output logic [PC_W-1:0] if_id_pc,
   output logic            if_id_predict_taken,
   output logic            if_id_btb_hit,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]     perf_redirects,
   output logic [15:0]     perf_fetches,
`endif
   output logic [PC_W-1:0] if_id_predict_target
);
   typedef enum logic {RUN, WAIT_RDIR} state_t;
   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pend_q, pend_d, ppc_q, ppc_d, ptgt_q, ptgt_d;
   logic [PC_W-1:0] redirect_pc, seq_pc;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d, ptaken_q, ptaken_d, hit_q, hit_d;
   logic            target_miss, redirect, fetch;
   always_comb begin
      target_miss = ex_mem_predict_taken && actual_taken && (ex_mem_predict_target != ex_mem_branch_target);
      redirect    = ex_mem_valid && (!bpu_correct || target_miss);
      redirect_pc = actual_taken ? ex_mem_branch_target : ex_mem_pc_in + PC_W'(4);
      seq_pc      = (predict_taken && btb_hit) ? predict_target : pc_q + PC_W'(4);
      fetch       = (state_q == RUN) && !redirect && !stall && imem_ready;
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      valid_d     = valid_q;
      instr_d     = instr_q;
      ppc_d       = ppc_q;
      ptaken_d    = ptaken_q;
      hit_d       = hit_q;
      ptgt_d      = ptgt_q;
      if (state_q == RUN) begin
         if (redirect) begin
            valid_d = 1'b0;
            // Without imem_ready the address must stay put, so park the target.
            if (imem_ready) pc_d = redirect_pc;
            else begin
               pend_d  = redirect_pc;
               state_d = WAIT_RDIR;
            end
         end else if (!stall && !imem_ready) begin
            valid_d = 1'b0;
         end else if (fetch) begin
            pc_d     = seq_pc;
            valid_d  = 1'b1;
            instr_d  = imem_rdata;
            ppc_d    = pc_q;
            ptaken_d = predict_taken;
            hit_d    = btb_hit;
            ptgt_d   = predict_target;
         end
      end else begin
         // The word returned for the wrong-path address is dropped.
         valid_d = 1'b0;
         if (redirect) pend_d = redirect_pc;
         if (imem_ready) begin
            pc_d    = redirect ? redirect_pc : pend_q;
            state_d = RUN;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         pend_q   <= RESET_PC;
         valid_q  <= 1'b0;
         instr_q  <= 32'h0000_0013;
         ppc_q    <= '0;
         ptaken_q <= 1'b0;
         hit_q    <= 1'b0;
         ptgt_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pend_q   <= pend_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         ppc_q    <= ppc_d;
         ptaken_q <= ptaken_d;
         hit_q    <= hit_d;
         ptgt_q   <= ptgt_d;
      end
   end
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] redirects_q, redirects_d, fetches_q, fetches_d;
   always_comb begin
      redirects_d = (redirect && redirects_q != 16'hFFFF) ? redirects_q + 16'd1 : redirects_q;
      fetches_d   = (fetch && fetches_q != 16'hFFFF) ? fetches_q + 16'd1 : fetches_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         redirects_q <= '0;
         fetches_q   <= '0;
      end else begin
         redirects_q <= redirects_d;
         fetches_q   <= fetches_d;
      end
   end
   assign perf_redirects = redirects_q;
   assign perf_fetches   = fetches_q;
`endif
   assign pc_out               = pc_q;
   assign flush                = redirect;
   assign if_id_valid          = valid_q;
   assign if_id_instr          = instr_q;
   assign if_id_pc             = ppc_q;
   assign if_id_predict_taken  = ptaken_q;
   assign if_id_btb_hit        = hit_q;
   assign if_id_predict_target = ptgt_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed self-checking bench for fetch_pc_unit.
module tb_fetch_pc_unit;
   logic        clk = 0, reset, stall, imem_ready, predict_taken, btb_hit;
   logic [31:0] imem_rdata;
   logic [11:0] predict_target, ex_mem_pc_in, ex_mem_predict_target, ex_mem_branch_target;
   logic        ex_mem_valid, ex_mem_predict_taken, bpu_correct, actual_taken;
   logic [11:0] pc_out, if_id_pc, if_id_predict_target;
   logic        flush, if_id_valid, if_id_predict_taken, if_id_btb_hit;
   logic [31:0] if_id_instr;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_redirects, perf_fetches;
`endif
   int checks = 0, errs = 0;
   always #5 clk = ~clk;
   fetch_pc_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .predict_taken(predict_taken), .btb_hit(btb_hit), .predict_target(predict_target),
      .ex_mem_valid(ex_mem_valid), .ex_mem_pc_in(ex_mem_pc_in),
      .ex_mem_predict_taken(ex_mem_predict_taken), .ex_mem_predict_target(ex_mem_predict_target),
      .ex_mem_branch_target(ex_mem_branch_target), .bpu_correct(bpu_correct),
      .actual_taken(actual_taken), .pc_out(pc_out), .flush(flush), .if_id_valid(if_id_valid),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_predict_taken(if_id_predict_taken),
      .if_id_btb_hit(if_id_btb_hit),
`ifdef FETCH_PERF_CNT_EN
      .perf_redirects(perf_redirects), .perf_fetches(perf_fetches),
`endif
      .if_id_predict_target(if_id_predict_target));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic clear_ex;
      ex_mem_valid = 0; bpu_correct = 1; actual_taken = 0; ex_mem_predict_taken = 0;
      ex_mem_pc_in = 0; ex_mem_predict_target = 0; ex_mem_branch_target = 0;
   endtask
   task automatic test_reset;
      reset = 0; stall = 0; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
      predict_taken = 1; btb_hit = 1; predict_target = 12'h555; clear_ex();
      tick(); tick();
      checks++; if (pc_out !== 12'h000) begin errs++; $display("FAIL reset_pc got %h want 000", pc_out); end
      checks++; if (if_id_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
      checks++; if (if_id_instr !== 32'h0000_0013) begin errs++; $display("FAIL reset_instr got %h want 00000013", if_id_instr); end
      checks++; if ({if_id_pc, if_id_predict_taken, if_id_btb_hit, if_id_predict_target} !== 26'h0) begin
         errs++; $display("FAIL reset_meta got %h/%b/%b/%h want 0", if_id_pc, if_id_predict_taken, if_id_btb_hit, if_id_predict_target); end
      checks++; if (flush !== 1'b0) begin errs++; $display("FAIL reset_flush got %b want 0", flush); end
      predict_taken = 0; btb_hit = 0; predict_target = 0;
   endtask
   task automatic test_free_run;
      reset = 1; imem_rdata = 32'hA000_0000;
      tick();
      checks++; if (pc_out !== 12'h004) begin errs++; $display("FAIL run_pc1 got %h want 004", pc_out); end
      checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 12'h000, 32'hA000_0000}) begin
         errs++; $display("FAIL run_ifid1 got %b/%h/%h want 1/000/a0000000", if_id_valid, if_id_pc, if_id_instr); end
      imem_rdata = 32'hA000_0004;
      tick();
      checks++; if (pc_out !== 12'h008) begin errs++; $display("FAIL run_pc2 got %h want 008", pc_out); end
      checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 12'h004, 32'hA000_0004}) begin
         errs++; $display("FAIL run_ifid2 got %b/%h/%h want 1/004/a0000004", if_id_valid, if_id_pc, if_id_instr); end
      tick(); tick();
   endtask
   task automatic test_predict;
      checks++; if (pc_out !== 12'h010) begin errs++; $display("FAIL pred_start got %h want 010", pc_out); end
      predict_taken = 1; btb_hit = 1; predict_target = 12'h040; imem_rdata = 32'hB000_0010;
      tick();
      checks++; if (pc_out !== 12'h040) begin errs++; $display("FAIL pred_pc got %h want 040", pc_out); end
      checks++; if ({if_id_valid, if_id_pc, if_id_predict_taken, if_id_btb_hit, if_id_predict_target, if_id_instr}
                    !== {1'b1, 12'h010, 1'b1, 1'b1, 12'h040, 32'hB000_0010}) begin
         errs++; $display("FAIL pred_ifid got %b/%h/%b/%b/%h/%h want 1/010/1/1/040/b0000010", if_id_valid, if_id_pc,
                          if_id_predict_taken, if_id_btb_hit, if_id_predict_target, if_id_instr); end
      btb_hit = 0; predict_target = 12'h200;
      tick();
      checks++; if (pc_out !== 12'h044) begin errs++; $display("FAIL pred_nohit_pc got %h want 044", pc_out); end
      checks++; if ({if_id_predict_taken, if_id_btb_hit, if_id_predict_target} !== {1'b1, 1'b0, 12'h200}) begin
         errs++; $display("FAIL pred_nohit_meta got %b/%b/%h want 1/0/200", if_id_predict_taken, if_id_btb_hit, if_id_predict_target); end
      predict_taken = 0; predict_target = 0;
   endtask
   task automatic test_mispredict;
      ex_mem_valid = 1; bpu_correct = 0; actual_taken = 0; ex_mem_pc_in = 12'h020;
      #1;
      checks++; if (flush !== 1'b1) begin errs++; $display("FAIL mis_flush got %b want 1", flush); end
      tick();
      clear_ex();
      checks++; if ({pc_out, if_id_valid} !== {12'h024, 1'b0}) begin
         errs++; $display("FAIL mis_pc got %h/%b want 024/0", pc_out, if_id_valid); end
      imem_rdata = 32'hC000_0024;
      tick();
      checks++; if ({pc_out, if_id_valid, if_id_pc, if_id_instr} !== {12'h028, 1'b1, 12'h024, 32'hC000_0024}) begin
         errs++; $display("FAIL mis_penalty got %h/%b/%h/%h want 028/1/024/c0000024", pc_out, if_id_valid, if_id_pc, if_id_instr); end
   endtask
   task automatic test_target_miss;
      ex_mem_valid = 0; bpu_correct = 0;
      #1;
      checks++; if (flush !== 1'b0) begin errs++; $display("FAIL nv_flush got %b want 0", flush); end
      ex_mem_valid = 1; bpu_correct = 1; ex_mem_predict_taken = 1; actual_taken = 1;
      ex_mem_predict_target = 12'h0A0; ex_mem_branch_target = 12'h0A0;
      #1;
      checks++; if (flush !== 1'b0) begin errs++; $display("FAIL tgt_match_flush got %b want 0", flush); end
      ex_mem_predict_target = 12'h080;
      #1;
      checks++; if (flush !== 1'b1) begin errs++; $display("FAIL tgt_miss_flush got %b want 1", flush); end
      tick();
      clear_ex();
      checks++; if ({pc_out, if_id_valid} !== {12'h0A0, 1'b0}) begin
         errs++; $display("FAIL tgt_miss_pc got %h/%b want 0a0/0", pc_out, if_id_valid); end
   endtask
   task automatic test_redirect_wait;
      imem_ready = 0; ex_mem_valid = 1; bpu_correct = 0; actual_taken = 1; ex_mem_branch_target = 12'h100;
      tick();
      clear_ex();
      for (int i = 0; i < 2; i++) begin
         checks++; if ({pc_out, if_id_valid} !== {12'h0A0, 1'b0}) begin
            errs++; $display("FAIL wait_hold%0d got %h/%b want 0a0/0", i, pc_out, if_id_valid); end
         tick();
      end
      checks++; if ({pc_out, if_id_valid} !== {12'h0A0, 1'b0}) begin
         errs++; $display("FAIL wait_hold2 got %h/%b want 0a0/0", pc_out, if_id_valid); end
      imem_ready = 1; stall = 1; imem_rdata = 32'hEEEE_0000;
      tick();
      stall = 0;
      checks++; if ({pc_out, if_id_valid} !== {12'h100, 1'b0}) begin
         errs++; $display("FAIL wait_release got %h/%b want 100/0", pc_out, if_id_valid); end
      imem_rdata = 32'hD000_0100;
      tick();
      checks++; if ({pc_out, if_id_valid, if_id_pc, if_id_instr} !== {12'h104, 1'b1, 12'h100, 32'hD000_0100}) begin
         errs++; $display("FAIL wait_first got %h/%b/%h/%h want 104/1/100/d0000100", pc_out, if_id_valid, if_id_pc, if_id_instr); end
   endtask
   task automatic test_wait_overwrite;
      imem_ready = 0; ex_mem_valid = 1; bpu_correct = 0; actual_taken = 0; ex_mem_pc_in = 12'h2FC;
      tick();
      actual_taken = 1; ex_mem_branch_target = 12'h340;
      tick();
      clear_ex();
      checks++; if (pc_out !== 12'h104) begin errs++; $display("FAIL ovw_hold got %h want 104", pc_out); end
      imem_ready = 1;
      tick();
      checks++; if ({pc_out, if_id_valid} !== {12'h340, 1'b0}) begin
         errs++; $display("FAIL ovw_pc got %h/%b want 340/0", pc_out, if_id_valid); end
   endtask
   task automatic test_stall;
      imem_rdata = 32'h5000_0340;
      tick();
      stall = 1; imem_rdata = 32'h6666_6666; predict_taken = 1; btb_hit = 1; predict_target = 12'h500;
      tick(); tick();
      checks++; if ({pc_out, if_id_valid, if_id_pc, if_id_instr, if_id_predict_taken, if_id_btb_hit, if_id_predict_target}
                    !== {12'h344, 1'b1, 12'h340, 32'h5000_0340, 1'b0, 1'b0, 12'h000}) begin
         errs++; $display("FAIL stall_hold got %h/%b/%h/%h/%b/%b/%h want 344/1/340/50000340/0/0/000", pc_out, if_id_valid,
                          if_id_pc, if_id_instr, if_id_predict_taken, if_id_btb_hit, if_id_predict_target); end
      ex_mem_valid = 1; bpu_correct = 0; actual_taken = 0; ex_mem_pc_in = 12'h3FC;
      tick();
      clear_ex(); stall = 0; predict_taken = 0; btb_hit = 0; predict_target = 0;
      checks++; if ({pc_out, if_id_valid} !== {12'h400, 1'b0}) begin
         errs++; $display("FAIL stall_redirect got %h/%b want 400/0", pc_out, if_id_valid); end
      imem_ready = 0;
      tick();
      checks++; if ({pc_out, if_id_valid} !== {12'h400, 1'b0}) begin
         errs++; $display("FAIL bubble got %h/%b want 400/0", pc_out, if_id_valid); end
      imem_ready = 1;
      tick();
      checks++; if ({pc_out, if_id_valid, if_id_pc} !== {12'h404, 1'b1, 12'h400}) begin
         errs++; $display("FAIL bubble_resume got %h/%b/%h want 404/1/400", pc_out, if_id_valid, if_id_pc); end
   endtask
   task automatic test_wrap;
      ex_mem_valid = 1; bpu_correct = 0; actual_taken = 1; ex_mem_branch_target = 12'hFFC;
      tick();
      clear_ex();
      checks++; if (pc_out !== 12'hFFC) begin errs++; $display("FAIL wrap_setup got %h want ffc", pc_out); end
      tick();
      checks++; if ({pc_out, if_id_valid, if_id_pc} !== {12'h000, 1'b1, 12'hFFC}) begin
         errs++; $display("FAIL wrap_seq got %h/%b/%h want 000/1/ffc", pc_out, if_id_valid, if_id_pc); end
      ex_mem_valid = 1; bpu_correct = 0; actual_taken = 0; ex_mem_pc_in = 12'hFFC;
      tick();
      clear_ex();
      checks++; if (pc_out !== 12'h000) begin errs++; $display("FAIL wrap_redirect got %h want 000", pc_out); end
   endtask
   task automatic test_reset_mid_wait;
      tick();
      imem_ready = 0; ex_mem_valid = 1; bpu_correct = 0; actual_taken = 1; ex_mem_branch_target = 12'h700;
      tick();
      clear_ex(); reset = 0;
      tick();
      checks++; if ({pc_out, if_id_valid} !== {12'h000, 1'b0}) begin
         errs++; $display("FAIL rst_wait got %h/%b want 000/0", pc_out, if_id_valid); end
      reset = 1; imem_ready = 1;
      tick();
      checks++; if ({pc_out, if_id_valid, if_id_pc} !== {12'h004, 1'b1, 12'h000}) begin
         errs++; $display("FAIL rst_wait_drop got %h/%b/%h want 004/1/000", pc_out, if_id_valid, if_id_pc); end
   endtask
   initial begin
      test_reset();
      test_free_run();
      test_predict();
      test_mispredict();
      test_target_miss();
      test_redirect_wait();
      test_wait_overwrite();
      test_stall();
      test_wrap();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage: owns the PC register, chooses the next PC from the branch prediction unit's outputs, and recovers from mispredictions resolved in EX/MEM. It drives the fetch address to instruction memory and to the prediction unit's `pc_in`. It captures the fetched word and the prediction metadata into the IF/ID pipeline register. Downstream, the decode stage and the hazard logic consume `if_id_*` and `flush`.

## Interface
Parameters:
- `PC_W`, 12, PC / address width in bits (byte address, word aligned).
- `RESET_PC`, 12'h000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `stall`  in  1  hazard-unit hold request for IF and IF/ID.
- `imem_ready`  in  1  instruction memory has valid data for `pc_out` this cycle.
- `imem_rdata`  in  32  instruction word at `pc_out`.
- `predict_taken`, `btb_hit`  in  1 each  prediction for current `pc_out`.
- `predict_target`  in  PC_W  predicted target for current `pc_out`.
- `ex_mem_valid`  in  1  EX/MEM holds a real instruction.
- `ex_mem_pc_in`  in  PC_W  PC of the EX/MEM instruction.
- `ex_mem_predict_taken`  in  1  prediction carried down with the EX/MEM instruction.
- `ex_mem_predict_target`  in  PC_W  target carried down with the EX/MEM instruction.
- `ex_mem_branch_target`  in  PC_W  resolved target.
- `bpu_correct`, `actual_taken`  in  1 each  taken/not-taken verdict from the prediction unit.
- `pc_out`  out  PC_W  current fetch address (imem address and BPU `pc_in`).
- `flush`  out  1  combinational redirect indication; the hazard logic kills ID/EX when it is high.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_instr`  out  32  fetched instruction.
- `if_id_pc`  out  PC_W  PC of the fetched instruction.
- `if_id_predict_taken`, `if_id_btb_hit`  out  1 each  prediction metadata.
- `if_id_predict_target`  out  PC_W  predicted target.

## Operation
- `target_miss` = `ex_mem_predict_taken && actual_taken && (ex_mem_predict_target != ex_mem_branch_target)`.
- `redirect` = `ex_mem_valid && (!bpu_correct || target_miss)`.
- `flush` = `redirect`.
- `redirect_pc` = `actual_taken ? ex_mem_branch_target : ex_mem_pc_in + 4`. Addition is modulo 2^PC_W.
- `seq_pc` = `(predict_taken && btb_hit) ? predict_target : pc_out + 4`. Addition wraps from 12'hFFC to 12'h000.
- FSM, two states: RUN and WAIT_RDIR. `pend_pc` is a PC_W register.
- RUN:
  - `redirect && imem_ready`: pc <= redirect_pc; if_id_valid <= 0.
  - `redirect && !imem_ready`: pend_pc <= redirect_pc; pc held (imem address must stay stable while the request is pending); if_id_valid <= 0; go to WAIT_RDIR.
  - else `stall`: pc held; all IF/ID fields held.
  - else `!imem_ready`: pc held; if_id_valid <= 0 (bubble).
  - else: pc <= seq_pc; IF/ID <= {1, imem_rdata, pc_out, predict_taken, btb_hit, predict_target}.
- WAIT_RDIR:
  - if_id_valid <= 0 every cycle.
  - A new `redirect` overwrites pend_pc.
  - When `imem_ready`: pc <= pend_pc (or redirect_pc if a redirect is asserted that cycle); the returned word is discarded; go to RUN.
  - `stall` is ignored in this state.
- Priority: reset > redirect > stall > imem wait > prediction > pc+4.

## Timing
- Reset values:
  - pc_out = RESET_PC
  - state = RUN
  - pend_pc = RESET_PC
  - if_id_valid = 0, if_id_instr = 32'h0000_0013 (NOP), if_id_pc = 0
  - if_id_predict_taken = 0, if_id_btb_hit = 0, if_id_predict_target = 0
  - counters = 0
- Reset asserted mid-WAIT_RDIR drops the pending redirect.
- Fetch-to-IF/ID latency: 1 cycle when `imem_ready`. Throughput: one instruction per cycle.
- Redirect penalty: the first correct-path instruction appears in IF/ID 2 cycles after `flush` when `imem_ready` stays high.
- `flush` has the same cycle as the EX/MEM inputs and no registered delay.
- `pc_out` changes only on a clock edge and never while `imem_ready` is low.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `perf_redirects` [15:0] and `perf_fetches` [15:0], both saturating at 16'hFFFF.
  - `perf_redirects` increments on each cycle with `redirect`.
  - `perf_fetches` increments on each IF/ID load with valid=1.
- Macro not defined: neither the ports nor the counters exist.

## Test plan
- Reset then free run, imem_ready=1, no prediction → pc_out 000, 004, 008; if_id_pc lags one cycle with if_id_valid=1.
- Prediction: pc_out=010, predict_taken=1, btb_hit=1, predict_target=040 → next pc_out=040; if_id_predict_taken=1, if_id_predict_target=040.
- Mispredict not-taken: ex_mem_valid=1, bpu_correct=0, actual_taken=0, ex_mem_pc_in=020 → flush=1; pc_out=024 next cycle; if_id_valid=0.
- Target miss: predicted and actual taken, predict_target=080, branch_target=0A0 → flush=1; pc_out=0A0.
- Redirect with imem_ready=0 for 3 cycles, redirect_pc=100 → pc_out held; if_id_valid=0 throughout; pc_out=100 the cycle after imem_ready rises.
- Stall and redirect in the same cycle → redirect wins. Stall alone holds pc_out and all IF/ID fields unchanged. Wrap: pc_out=FFC with no prediction → 000.
